inv_witness_search_ctrl: RTL
============================

Name: inv_witness_search_ctrl

Overview:
- Sequential controller that finds an invertibility witness x for the bit-vector constraint bvslt(bvlshr(x, s), t).
- Accepts an (s, t) query over a valid/ready handshake and sweeps candidate x values, evaluating one candidate per cycle through a single shared lshr + signed-compare datapath.
- Returns the first satisfying x, or reports that no witness exists.
- Serves as the runtime cross-check and sequencer for the combinational Skolem-function witness blocks in the invertibility-condition suite.

Parameters:
- WIDTH, 4, bit width of s, t and x; the candidate sweep covers 0 to 2^WIDTH-1.
- CNT_W, WIDTH+1, width of the candidate counter and of out_evals.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  query valid.
- in_ready  out  1  controller can accept a query; high only in IDLE.
- in_s  in  WIDTH  shift amount s, unsigned.
- in_t  in  WIDTH  bound t, two's complement.
- flush  in  1  synchronous abort; forces IDLE.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_found  out  1  1 = witness exists.
- out_x  out  WIDTH  witness value; 0 when not found.
- out_evals  out  CNT_W  number of candidates evaluated for this query.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_found=0, out_x=0, out_evals=0, internal cnt=0, s_q=0, t_q=0.
- States are IDLE, SEARCH and DONE.
- IDLE → SEARCH on in_valid & in_ready. The same edge captures s_q=in_s and t_q=in_t and clears cnt.
- Datapath, combinational on registered values:
  - sh = (s_q >= WIDTH) ? 0 : (cnt[WIDTH-1:0] >> s_q), logical shift.
  - hit = $signed(sh) < $signed(t_q).
- SEARCH, one candidate per cycle:
  - hit → DONE, out_found=1, out_x=cnt, out_evals=cnt+1.
  - !hit and cnt == 2^WIDTH-1 → DONE, out_found=0, out_x=0, out_evals=2^WIDTH.
  - otherwise cnt <= cnt+1.
- Latency: for a first witness at index k, out_valid rises k+1 edges after the accept edge. For no witness, out_valid rises 2^WIDTH edges after the accept edge.
- DONE holds out_valid and all result outputs stable until out_ready. DONE → IDLE on out_ready; outputs are held until the next accept.
- Back-to-back queries: a new query is accepted at the earliest on the cycle after the DONE→IDLE edge. in_ready is never high in the same cycle as out_valid.
- flush in any state → IDLE on the next edge; out_valid=0; result registers are unchanged. flush has priority over all other transitions, including accept and out_ready.
- Inputs other than in_valid and flush are ignored in SEARCH. in_s and in_t changing mid-search has no effect.
- Asynchronous reset mid-search: immediate return to reset values; the query is lost.
- The counter never wraps: termination is checked before increment. CNT_W must hold 2^WIDTH.

Optional Feature:
- Macro: SKOLEM_HINT_EN.
- With the macro:
  - Adds input in_hint [WIDTH-1:0], captured with s and t.
  - Adds output out_hint_used [1].
  - SEARCH first evaluates the hint for one cycle (state HINT, entered from IDLE instead of SEARCH).
  - If the hint satisfies → DONE with out_x=hint, out_found=1, out_evals=1, out_hint_used=1.
  - Otherwise → SEARCH from cnt=0; out_evals counts the hint cycle (k+2 for a witness at index k), and out_hint_used=0.
- Without the macro: the ports are absent, there is no HINT state, and behaviour is as above.

Test Plan:
- s=1, t=3: x=0 gives 0<3. Expect out_valid 1 edge after accept, found=1, x=0, evals=1.
- s=0, t=0: the first negative x is 8. Expect out_valid 9 edges after accept, found=1, x=8 (4'b1000), evals=9.
- s=2, t=0: sh is at most 3 and never negative. Expect out_valid 16 edges after accept, found=0, x=0, evals=16. Repeat with t=8 (-8) and any s: found=0.
- s=5 (≥WIDTH) with t=1 → found=1, x=0. With t=0 → found=0, evals=16.
- Handshake: hold out_ready=0 for 5 cycles in DONE and check outputs are stable and in_ready=0. Assert flush at the 4th SEARCH cycle of the s=0, t=0 query: IDLE next edge, out_valid never rises. Assert rst_n low mid-search: outputs reset immediately.
- SKOLEM_HINT_EN:
  - s=0, t=0, hint=12 → found=1, x=12, evals=1, hint_used=1, out_valid 1 edge after accept.
  - hint=3 → x=8, evals=10, hint_used=0.

Source files
------------

// File: rtl/inv_witness_search_ctrl.sv
// Sequential witness search for bvslt(bvlshr(x, s), t): one candidate per cycle through a shared shift/compare path.
// Optional SKOLEM_HINT_EN adds a one-cycle hint evaluation before the linear sweep.
`default_nettype none

module inv_witness_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_t,
`ifdef SKOLEM_HINT_EN
  input  logic [WIDTH-1:0] in_hint,
  output logic             out_hint_used,
`endif
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [WIDTH-1:0] out_x,
  output logic [CNT_W-1:0] out_evals
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
`ifdef SKOLEM_HINT_EN
  localparam logic [1:0] HINT   = 2'd3;
  localparam logic [CNT_W-1:0] EV_OFF = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] EV_OFF = CNT_W'(1);
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << WIDTH) - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] t_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sh;
  logic             hit;
`ifdef SKOLEM_HINT_EN
  logic [WIDTH-1:0] hint_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The hint and the sweep counter share one shift/compare path.
  always_comb begin
    cand = cnt[WIDTH-1:0];
`ifdef SKOLEM_HINT_EN
    if (state == HINT) cand = hint_q;
`endif
  end

  always_comb begin
    sh = '0;
    if (32'(s_q) < 32'(WIDTH)) sh = cand >> s_q;
  end

  assign hit = $signed(sh) < $signed(t_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      t_q       <= '0;
      cnt       <= '0;
      out_found <= 1'b0;
      out_x     <= '0;
      out_evals <= '0;
`ifdef SKOLEM_HINT_EN
      hint_q        <= '0;
      out_hint_used <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_q <= in_s;
            t_q <= in_t;
            cnt <= '0;
`ifdef SKOLEM_HINT_EN
            hint_q <= in_hint;
            state  <= HINT;
`else
            state  <= SEARCH;
`endif
          end
        end
`ifdef SKOLEM_HINT_EN
        HINT: begin
          if (hit) begin
            state         <= DONE;
            out_found     <= 1'b1;
            out_x         <= hint_q;
            out_evals     <= CNT_W'(1);
            out_hint_used <= 1'b1;
          end else begin
            state <= SEARCH;
          end
        end
`endif
        SEARCH: begin
          // Termination is decided before the increment so cnt never wraps.
          if (hit) begin
            state     <= DONE;
            out_found <= 1'b1;
            out_x     <= cnt[WIDTH-1:0];
            out_evals <= cnt + EV_OFF;
`ifdef SKOLEM_HINT_EN
            out_hint_used <= 1'b0;
`endif
          end else if (cnt == LAST) begin
            state     <= DONE;
            out_found <= 1'b0;
            out_x     <= '0;
            out_evals <= LAST + EV_OFF;
`ifdef SKOLEM_HINT_EN
            out_hint_used <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
